line_word_adapter: RTL and testbench

LINE_WORD_ADAPTER -- requirements
Module: line_word_adapter

---
 rtl/line_word_adapter_pkg.sv | 6 +
 rtl/line_word_adapter.sv | 85 ++++++++
 tb/tb_line_word_adapter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/line_word_adapter_pkg.sv
// memory_bus_sizes: shared cache-line and memory-word widths
package memory_bus_sizes;
  localparam int LINE_WIDTH = 128;
  localparam int WORD_WIDTH = 32;
  localparam int WORDS_PER_LINE = 4;
endpackage

// File: rtl/line_word_adapter.sv
// line_word_adapter: turns 128-bit dcache line fills/writebacks into four 32-bit memory beats
module line_word_adapter
  import memory_bus_sizes::LINE_WIDTH, memory_bus_sizes::WORD_WIDTH;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [31:0]           line_read_addr,
  input  logic                  line_read_addr_valid,
  output logic                  line_read_addr_ready,
  output logic [LINE_WIDTH-1:0] line_read_data,
  output logic                  line_read_data_valid,
  input  logic [31:0]           line_write_addr,
  input  logic                  line_write_addr_valid,
  input  logic [LINE_WIDTH-1:0] line_write_data,
  output logic                  line_write_addr_ready,
  output logic                  line_write_resp_valid,
  output logic [31:0]           mem_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_BEAT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_BEAT = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  logic [2:0] state;
  logic [1:0] beat;
  logic [27:0] base;
  logic [LINE_WIDTH-1:0] lbuf, filled;
  logic busy, last, unused;
  assign unused = ^{line_read_addr[3:0], line_write_addr[3:0]};
  assign busy = state == RD_BEAT || state == WR_BEAT;
  assign last = beat == 2'(WORDS_PER_LINE - 1);
  assign line_read_addr_ready = state == IDLE && !RESET;
  assign line_write_addr_ready = state == IDLE && !RESET;
  assign line_read_data_valid = state == RD_RESP;
  assign line_write_resp_valid = state == WR_RESP;
  assign mem_req = busy;
  assign mem_we = state == WR_BEAT;
  assign mem_addr = busy ? {base, beat, 2'b00} : '0;
  assign mem_wdata = mem_we ? lbuf[{beat, 5'd0} +: WORD_WIDTH] : '0;
  always_comb begin
    filled = lbuf;
    filled[{beat, 5'd0} +: WORD_WIDTH] = mem_rdata;
  end
  // line_read_data is only refreshed on the final beat so it holds the previous line during a fill
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      beat <= '0;
      base <= '0;
      lbuf <= '0;
      line_read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write_addr_valid) begin
            state <= WR_BEAT;
            base <= line_write_addr[31:4];
            lbuf <= line_write_data;
            beat <= '0;
          end else if (line_read_addr_valid) begin
            state <= RD_BEAT;
            base <= line_read_addr[31:4];
            beat <= '0;
          end
        end
        RD_BEAT, WR_BEAT: begin
          if (mem_ack) begin
            beat <= beat + 2'd1;
            if (state == RD_BEAT) lbuf <= filled;
            if (last) state <= state == RD_BEAT ? RD_RESP : WR_RESP;
            if (last && state == RD_BEAT) line_read_data <= filled;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_word_adapter.sv
// tb_line_word_adapter: random and directed line transactions checked against a word-level transaction model
module tb_line_word_adapter;
  logic clk = 0;
  logic RESET;
  logic [31:0] line_read_addr, line_write_addr, mem_addr;
  logic line_read_addr_valid, line_read_addr_ready, line_read_data_valid;
  logic line_write_addr_valid, line_write_addr_ready, line_write_resp_valid;
  logic [127:0] line_read_data, line_write_data;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_wdata, mem_rdata;
  int checks = 0, errors = 0, acks = 0;
  logic [127:0] last_line = '0;

  line_word_adapter dut (
    .clk(clk), .RESET(RESET),
    .line_read_addr(line_read_addr), .line_read_addr_valid(line_read_addr_valid),
    .line_read_addr_ready(line_read_addr_ready), .line_read_data(line_read_data),
    .line_read_data_valid(line_read_data_valid),
    .line_write_addr(line_write_addr), .line_write_addr_valid(line_write_addr_valid),
    .line_write_data(line_write_data), .line_write_addr_ready(line_write_addr_ready),
    .line_write_resp_valid(line_write_resp_valid),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outputs(input string tag, input logic [1:0] rdy);
    chk({tag, "_ready"}, {126'b0, line_read_addr_ready, line_write_addr_ready}, {126'b0, rdy});
    chk({tag, "_req"}, {127'b0, mem_req}, 128'd0);
    chk({tag, "_pulses"}, {126'b0, line_read_data_valid, line_write_resp_valid}, 128'd0);
  endtask

  // One whole line transaction; w < 0 picks 0..2 wait cycles per beat at random
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [127:0] d,
                        input int w, input bit seq, input bit hold_rd);
    logic [127:0] line;
    logic [31:0] base;
    int nw;
    line = '0;
    chk("accept_ready", {126'b0, line_read_addr_ready, line_write_addr_ready}, {126'b0, 2'b11});
    if (wr) begin
      line_write_addr = a;
      line_write_data = d;
      line_write_addr_valid = 1;
    end else begin
      line_read_addr = a;
      line_read_addr_valid = 1;
    end
    tick;
    line_write_addr_valid = 0;
    line_write_addr = $urandom;
    line_write_data = {$urandom, $urandom, $urandom, $urandom};
    if (!hold_rd) begin
      line_read_addr_valid = 0;
      line_read_addr = $urandom;
    end
    base = {a[31:4], 4'h0};
    for (int k = 0; k < 4; k++) begin
      nw = w < 0 ? int'($urandom_range(0, 2)) : w;
      for (int j = 0; j <= nw; j++) begin
        chk("beat_req", {127'b0, mem_req}, 128'd1);
        chk("beat_addr", {96'b0, mem_addr}, {96'b0, base + 32'(4 * k)});
        chk("beat_we", {127'b0, mem_we}, {127'b0, wr});
        if (wr) chk("beat_wdata", {96'b0, mem_wdata}, {96'b0, d[32*k +: 32]});
        chk("beat_ready", {126'b0, line_read_addr_ready, line_write_addr_ready}, 128'd0);
        mem_ack = j == nw;
        mem_rdata = mem_ack && seq ? 32'(17 * (k + 1)) : $urandom;
        if (mem_ack) begin
          acks++;
          line[32*k +: 32] = mem_rdata;
        end
        tick;
      end
    end
    mem_ack = 0;
    chk("rd_pulse", {127'b0, line_read_data_valid}, {127'b0, !wr});
    chk("wr_pulse", {127'b0, line_write_resp_valid}, {127'b0, wr});
    chk("resp_req", {127'b0, mem_req}, 128'd0);
    if (!wr) last_line = line;
    chk("resp_line", line_read_data, last_line);
    tick;
    idle_outputs("after_resp", 2'b11);
    chk("hold_line", line_read_data, last_line);
  endtask

  initial begin
    RESET = 1;
    line_read_addr = 0; line_read_addr_valid = 0;
    line_write_addr = 0; line_write_addr_valid = 0; line_write_data = 0;
    mem_ack = 0; mem_rdata = 0;
    tick;
    tick;
    idle_outputs("reset", 2'b00);
    chk("reset_line", line_read_data, 128'd0);
    chk("reset_addr", {96'b0, mem_addr}, 128'd0);
    RESET = 0;
    tick;
    idle_outputs("post_reset", 2'b11);

    // zero-wait fill returning 0x11..0x44
    do_txn(0, 32'h0000_1234, '0, 0, 1, 0);
    chk("fill_line", line_read_data, 128'h00000044_00000033_00000022_00000011);

    // writeback with two wait cycles per beat
    do_txn(1, 32'hABCD_0010, {{4{8'hDD}}, {4{8'hCC}}, {4{8'hBB}}, {4{8'hAA}}}, 2, 0, 0);

    // write and read raised together: write first, read right after
    acks = 0;
    line_read_addr = 32'h0000_5678;
    line_read_addr_valid = 1;
    do_txn(1, 32'h0000_9ABC, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
    do_txn(0, 32'h0000_5678, '0, 0, 0, 0);
    chk("handshakes", 128'(acks), 128'd8);

    // spurious mem_ack while idle
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = $urandom;
      tick;
      idle_outputs("spurious", 2'b11);
    end
    mem_ack = 0;
    chk("spurious_line", line_read_data, last_line);

    // reset during beat 2 of a read
    line_read_addr = 32'h0000_2000;
    line_read_addr_valid = 1;
    tick;
    line_read_addr_valid = 0;
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1;
      mem_rdata = $urandom;
      tick;
    end
    mem_ack = 0;
    chk("abort_addr", {96'b0, mem_addr}, 128'h2008);
    RESET = 1;
    tick;
    idle_outputs("abort", 2'b00);
    chk("abort_line", line_read_data, 128'd0);
    RESET = 0;
    last_line = '0;
    tick;
    idle_outputs("abort_release", 2'b11);
    chk("abort_release_line", line_read_data, 128'd0);

    for (int n = 0; n < 40; n++)
      do_txn($urandom_range(0, 1) == 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
